// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU run-control and statistics unit.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        STEP = 2'd2
    } run_state_t;

    localparam int SEL_CYCLE     = 0;
    localparam int EV_UNCOND     = 0;
    localparam int EV_COND       = 1;
    localparam int EV_COND_TAKEN = 2;

endpackage

// File: rtl/stat_counter.sv
// One statistics counter with synchronous clear and a sticky overflow flag.
// STAT_SATURATE_EN selects saturate-at-all-ones instead of wrap.
module stat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic at_max;

    assign at_max = &cnt;

    // clr outranks a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (inc) begin
            if (at_max) begin
                ovf <= 1'b1;
            end
`ifdef STAT_SATURATE_EN
            if (!at_max) begin
                cnt <= cnt + CNT_W'(1);
            end
`else
            cnt <= cnt + CNT_W'(1);
`endif
        end
    end

endmodule

// File: rtl/run_ctrl_stats.sv
// Run-control (CPU update enable, halt/step/resume) and cycle/event counters.
// Counter overflow behaviour is selected by STAT_SATURATE_EN (wrap when undefined).
module run_ctrl_stats
    import cpu_ctrl_pkg::*;
#(
    parameter int N_EV  = 3,
    parameter int CNT_W = 32,
    parameter int DIV_W = 21
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       change_hz,
    input  logic                       halt,
    input  logic                       resume,
    input  logic                       step,
    input  logic                       clr,
    input  logic [N_EV-1:0]            ev,
    input  logic [$clog2(N_EV+1)-1:0]  sel,
    output logic                       run_en,
    output logic                       halted,
    output logic [CNT_W-1:0]           rd_data,
    output logic [N_EV:0]              ovf
);

    run_state_t       state;
    run_state_t       state_nxt;
    logic             resume_q;
    logic             step_q;
    logic             hz_q;
    logic             resume_edge;
    logic             step_edge;
    logic             tc;
    logic [DIV_W-1:0] presc;
    logic [N_EV:0]    inc;
    logic [CNT_W-1:0] cnt [N_EV+1];
    logic [CNT_W-1:0] rd_nxt;

    assign resume_edge = resume & ~resume_q;
    assign step_edge   = step & ~step_q;
    assign tc          = hz_q | (&presc);

    // Decoded from registers only, so the CPU sees a glitch-free enable.
    assign run_en = ((state == RUN) & tc) | (state == STEP);
    assign halted = (state == HALT);

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:  if (run_en && halt) state_nxt = HALT;
            HALT: begin
                if (resume_edge)    state_nxt = RUN;
                else if (step_edge) state_nxt = STEP;
            end
            STEP: state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            resume_q <= 1'b0;
            step_q   <= 1'b0;
            hz_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            resume_q <= resume;
            step_q   <= step;
            hz_q     <= change_hz;
        end
    end

    // Restart the slow period on a rate change or on leaving HALT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if ((change_hz != hz_q) || (state == HALT && state_nxt == RUN)) begin
            presc <= '0;
        end else if (state == RUN) begin
            presc <= presc + DIV_W'(1);
        end
    end

    assign inc[SEL_CYCLE] = run_en;
    assign inc[N_EV:1]    = ev & {N_EV{run_en}};

    for (genvar i = 0; i <= N_EV; i++) begin : g_cnt
        stat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .inc (inc[i]),
            .cnt (cnt[i]),
            .ovf (ovf[i])
        );
    end

    always_comb begin
        rd_nxt = '0;
        for (int i = 0; i <= N_EV; i++) begin
            if (32'(sel) == 32'(i)) rd_nxt = cnt[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data <= '0;
        else     rd_data <= rd_nxt;
    end

endmodule

// File: tb/tb_run_ctrl_stats.sv
// Directed bench for run_ctrl_stats with DIV_W=4 and CNT_W=4 so slow periods and wraps stay short.
module tb_run_ctrl_stats;
    import cpu_ctrl_pkg::*;

    localparam int N_EV  = 3;
    localparam int CNT_W = 4;
    localparam int DIV_W = 4;

`ifdef STAT_SATURATE_EN
    localparam int WRAP_CNT1 = 15;
    localparam int WRAP_CNT0 = 15;
`else
    localparam int WRAP_CNT1 = 1;
    localparam int WRAP_CNT0 = 2;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             change_hz;
    logic             halt;
    logic             resume;
    logic             step;
    logic             clr;
    logic [N_EV-1:0]  ev;
    logic [1:0]       sel;
    logic             run_en;
    logic             halted;
    logic [CNT_W-1:0] rd_data;
    logic [N_EV:0]    ovf;

    int checks = 0;
    int errors = 0;

    run_ctrl_stats #(
        .N_EV  (N_EV),
        .CNT_W (CNT_W),
        .DIV_W (DIV_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .change_hz (change_hz),
        .halt      (halt),
        .resume    (resume),
        .step      (step),
        .clr       (clr),
        .ev        (ev),
        .sel       (sel),
        .run_en    (run_en),
        .halted    (halted),
        .rd_data   (rd_data),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        int first;
        int last;
        int n;
        logic gap_ok;
        logic found;

        rst = 1'b1; change_hz = 1'b0; halt = 1'b0; resume = 1'b0; step = 1'b0;
        clr = 1'b0; ev = '0; sel = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_run_en", 32'(run_en), 32'(0));
        chk("reset_halted", 32'(halted), 32'(0));
        chk("reset_rd_data", 32'(rd_data), 32'(0));
        chk("reset_ovf", 32'(ovf), 32'(0));

        // Fast mode: ten counted cycles with every event active
        rst = 1'b0; change_hz = 1'b1; clr = 1'b1;
        tick();
        chk("fast_run_en", 32'(run_en), 32'(1));
        clr = 1'b0; ev = 3'b111;
        repeat (9) tick();
        change_hz = 1'b0;
        tick();
        ev = '0;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            tick();
            chk($sformatf("fast_cnt_sel%0d", s), 32'(rd_data), 32'(10));
        end
        chk("fast_halted", 32'(halted), 32'(0));

        // Slow mode: rate change, clear, then observe 64 cycles
        change_hz = 1'b1;
        tick();
        change_hz = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        pulses = 0; first = -1; last = -1; gap_ok = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (run_en) begin
                if (first < 0) first = i;
                else if (i - last != 16) gap_ok = 1'b0;
                last = i;
                pulses++;
            end
        end
        chk("slow_first", 32'(first), 32'(13));
        chk("slow_pulses", 32'(pulses), 32'(4));
        chk("slow_gap", 32'(gap_ok), 32'(1));
        sel = 2'd0;
        tick();
        chk("slow_cnt0", 32'(rd_data), 32'(4));

        // Halt on the next run_en
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = run_en;
        end
        chk("halt_wait", 32'(found), 32'(1));
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_halted", 32'(halted), 32'(1));
        chk("halt_run_en", 32'(run_en), 32'(0));
        n = 0;
        repeat (20) begin
            tick();
            n += int'(run_en);
        end
        chk("halt_idle_run_en", 32'(n), 32'(0));
        chk("halt_idle_halted", 32'(halted), 32'(1));
        chk("halt_cnt0", 32'(rd_data), 32'(5));

        // Single step; halt is ignored while stepping
        step = 1'b1;
        tick();
        chk("step_run_en", 32'(run_en), 32'(1));
        chk("step_halted", 32'(halted), 32'(0));
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("step_back_halted", 32'(halted), 32'(1));
        chk("step_back_run_en", 32'(run_en), 32'(0));
        n = 0;
        repeat (5) begin
            tick();
            n += int'(run_en);
        end
        chk("step_level_no_repeat", 32'(n), 32'(0));
        step = 1'b0;
        repeat (2) tick();
        chk("step_cnt0", 32'(rd_data), 32'(6));

        // Resume restarts the slow period
        resume = 1'b1;
        tick();
        chk("resume_halted", 32'(halted), 32'(0));
        chk("resume_run_en", 32'(run_en), 32'(0));
        repeat (14) tick();
        chk("resume_pre_pulse", 32'(run_en), 32'(0));
        tick();
        chk("resume_first_pulse", 32'(run_en), 32'(1));
        halt = 1'b1;
        tick();
        halt = 1'b0; resume = 1'b0;
        tick();
        chk("rehalt_halted", 32'(halted), 32'(1));

        // Resume and step edges together: resume wins
        resume = 1'b1; step = 1'b1;
        tick();
        chk("both_halted", 32'(halted), 32'(0));
        chk("both_run_en", 32'(run_en), 32'(0));
        tick();
        chk("both_halted_next", 32'(halted), 32'(0));
        resume = 1'b0; step = 1'b0;

        // Overflow: 17 events on channel 0
        change_hz = 1'b1;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        ev = '0;
        ev[EV_UNCOND] = 1'b1;
        repeat (17) tick();
        ev = '0; change_hz = 1'b0;
        tick();
        sel = 2'd1;
        tick();
        chk("wrap_cnt1", 32'(rd_data), 32'(WRAP_CNT1));
        chk("wrap_ovf", 32'(ovf), 32'(4'b0011));
        sel = 2'd0;
        tick();
        chk("wrap_cnt0", 32'(rd_data), 32'(WRAP_CNT0));

        // Asynchronous reset in the middle of a slow period
        sel = 2'd1;
        repeat (3) tick();
        chk("pre_rst_rd_data", 32'(rd_data), 32'(WRAP_CNT1));
        rst = 1'b1;
        #1;
        chk("rst_run_en", 32'(run_en), 32'(0));
        chk("rst_halted", 32'(halted), 32'(0));
        chk("rst_rd_data", 32'(rd_data), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));
        tick();
        rst = 1'b0;
        repeat (14) tick();
        chk("post_rst_pre_pulse", 32'(run_en), 32'(0));
        tick();
        chk("post_rst_first_pulse", 32'(run_en), 32'(1));

        // Overflow every counter, then clear coincident with events
        change_hz = 1'b1; ev = 3'b111;
        repeat (17) tick();
        chk("pre_clr_ovf", 32'(ovf), 32'(4'b1111));
        clr = 1'b1;
        tick();
        chk("clr_ovf", 32'(ovf), 32'(0));
        ev = '0; sel = 2'd1;
        tick();
        chk("clr_cnt1", 32'(rd_data), 32'(0));
        change_hz = 1'b0;
        tick();
        clr = 1'b0; sel = 2'd0;
        tick();
        chk("clr_cnt0", 32'(rd_data), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
